bcd_updown_counter: RTL and testbench



---
 rtl/bcd_updown_counter.sv | 173 +++++++++++++++++
 tb/tb_bcd_updown_counter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//
// Multi-digit BCD up/down counter over 0..MAX_VAL. It takes one step per cycle
// while en_i is high and pause_i is low. It also has a synchronous clear and a
// validated parallel load. At the range limits it either wraps or holds,
// selected by SATURATE. tc_o cascades into the en_i of the next counter.
//
// Parameters
//   DIGITS   : number of BCD digits (1..8)
//   MAX_VAL  : terminal count as a decimal integer (1 .. 10^DIGITS-1)
//   SATURATE : 0 = wrap at the limits, 1 = hold at the limits
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   en_i         in   count tick
//   pause_i      in   freezes counting; clear and load still act
//   up_dn_i      in   1 = count up, 0 = count down
//   clear_i      in   synchronous clear to 0 (highest priority)
//   load_i       in   synchronous parallel load request
//   load_val_i   in   BCD load value, digit 0 in [3:0]
//   count_bcd_o  out  current BCD value, digit 0 in [3:0]
//   tc_o         out  one-cycle pulse coincident with a wrapped value
//   at_max_o     out  count_bcd_o == MAX_VAL
//   at_min_o     out  count_bcd_o == 0
//   load_err_o   out  one-cycle pulse after a rejected load
// -----------------------------------------------------------------------------
module bcd_updown_counter #(
  parameter int DIGITS   = 2,
  parameter int MAX_VAL  = 19,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  pause_i,
  input  logic                  up_dn_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  output logic [4*DIGITS-1:0]   count_bcd_o,
  output logic                  tc_o,
  output logic                  at_max_o,
  output logic                  at_min_o,
  output logic                  load_err_o
);

  localparam int W = 4 * DIGITS;

  // Decimal integer to packed BCD, evaluated at elaboration.
  function automatic logic [W-1:0] to_bcd(input int val);
    logic [W-1:0] res;
    int           rem;
    res = '0;
    rem = val;
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(rem % 10);
      rem           = rem / 10;
    end
    return res;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

  // Increment with ripple carry: a digit at 9 rolls to 0 and passes the carry on.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         carry;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // Decrement with ripple borrow: a digit at 0 rolls to 9 and passes the borrow on.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         borrow;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          res[4*i +: 4] = 4'd9;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
    return res;
  endfunction

  function automatic logic digits_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  logic [W-1:0] count_q, count_d;
  logic         tc_q, tc_d;
  logic         load_err_q, load_err_d;
  logic         load_ok;

  // Once every digit is known to be 0..9, a plain unsigned compare of the
  // packed vectors orders the values the same way as their decimal meaning.
  assign load_ok = digits_ok(load_val_i) && (load_val_i <= MAX_BCD);

  always_comb begin
    count_d    = count_q;
    tc_d       = 1'b0;
    load_err_d = 1'b0;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      if (load_ok) count_d    = load_val_i;
      else         load_err_d = 1'b1;
    end else if (en_i && !pause_i) begin
      if (up_dn_i) begin
        // ">=" also sends any value above MAX_VAL down the limit path.
        if (count_q >= MAX_BCD) begin
          if (!SATURATE) begin
            count_d = '0;
            tc_d    = 1'b1;
          end
        end else begin
          count_d = bcd_inc(count_q);
        end
      end else begin
        if (count_q == '0) begin
          if (!SATURATE) begin
            count_d = MAX_BCD;
            tc_d    = 1'b1;
          end
        end else begin
          count_d = bcd_dec(count_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign count_bcd_o = count_q;
  assign tc_o        = tc_q;
  assign load_err_o  = load_err_q;
  assign at_max_o    = (count_q == MAX_BCD);
  assign at_min_o    = (count_q == '0);

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, pause, up_dn, clear, load;
  logic [7:0]  lv_a;
  logic [11:0] lv_b;

  logic [7:0]  cnt_a;
  logic        tc_a, amax_a, amin_a, err_a;
  logic [11:0] cnt_b;
  logic        tc_b, amax_b, amin_b, err_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_updown_counter dut_a (
    .clk(clk), .rst_n(rst_n), .en_i(en), .pause_i(pause), .up_dn_i(up_dn),
    .clear_i(clear), .load_i(load), .load_val_i(lv_a),
    .count_bcd_o(cnt_a), .tc_o(tc_a), .at_max_o(amax_a), .at_min_o(amin_a),
    .load_err_o(err_a)
  );

  bcd_updown_counter #(.DIGITS(3), .MAX_VAL(599), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en), .pause_i(pause), .up_dn_i(up_dn),
    .clear_i(clear), .load_i(load), .load_val_i(lv_b),
    .count_bcd_o(cnt_b), .tc_o(tc_b), .at_max_o(amax_b), .at_min_o(amin_b),
    .load_err_o(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] c, input logic t, input logic e);
    check({tag, " count"},    32'(cnt_a),  32'(c));
    check({tag, " tc"},       32'(tc_a),   32'(t));
    check({tag, " load_err"}, 32'(err_a),  32'(e));
    check({tag, " at_max"},   32'(amax_a), 32'(c == 8'h19));
    check({tag, " at_min"},   32'(amin_a), 32'(c == 8'h00));
  endtask

  task automatic chk_b(input string tag, input logic [11:0] c, input logic t, input logic e);
    check({tag, " count"},    32'(cnt_b),  32'(c));
    check({tag, " tc"},       32'(tc_b),   32'(t));
    check({tag, " load_err"}, 32'(err_b),  32'(e));
    check({tag, " at_max"},   32'(amax_b), 32'(c == 12'h599));
    check({tag, " at_min"},   32'(amin_b), 32'(c == 12'h000));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dec2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; pause = 1'b0; up_dn = 1'b1;
    clear = 1'b0; load = 1'b0; lv_a = 8'h00; lv_b = 12'h000;

    #12;
    chk_a("reset_a", 8'h00, 1'b0, 1'b0);
    chk_b("reset_b", 12'h000, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Legacy 0..19 up count with wrap
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk_a($sformatf("up_%0d", i), (i == 20) ? 8'h00 : dec2bcd(i), i == 20, 1'b0);
    end

    // Down wrap from 0 to MAX_VAL
    up_dn = 1'b0;
    tick(); chk_a("down_wrap", 8'h19, 1'b1, 1'b0);
    tick(); chk_a("down_after_wrap", 8'h18, 1'b0, 1'b0);
    en = 1'b0;

    // Loads
    load = 1'b1; lv_a = 8'h07;
    tick(); chk_a("load_07", 8'h07, 1'b0, 1'b0);
    lv_a = 8'h1A;
    tick(); chk_a("load_bad_digit", 8'h07, 1'b0, 1'b1);
    load = 1'b0;
    tick(); chk_a("err_one_cycle_1", 8'h07, 1'b0, 1'b0);
    load = 1'b1; lv_a = 8'h25;
    tick(); chk_a("load_over_max", 8'h07, 1'b0, 1'b1);
    load = 1'b0;
    tick(); chk_a("err_one_cycle_2", 8'h07, 1'b0, 1'b0);
    load = 1'b1; lv_a = 8'h12;
    tick(); chk_a("load_12", 8'h12, 1'b0, 1'b0);
    lv_a = 8'h19;
    tick(); chk_a("load_max", 8'h19, 1'b0, 1'b0);
    lv_a = 8'h20;
    tick(); chk_a("load_max_plus1", 8'h19, 1'b0, 1'b1);

    // clear beats load and en; then pause freezes
    clear = 1'b1; load = 1'b1; en = 1'b1; lv_a = 8'h12;
    tick(); chk_a("clear_prio", 8'h00, 1'b0, 1'b0);
    clear = 1'b0; load = 1'b0; pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_a($sformatf("pause_%0d", i), 8'h00, 1'b0, 1'b0);
    end
    load = 1'b1; lv_a = 8'h05;
    tick(); chk_a("load_in_pause", 8'h05, 1'b0, 1'b0);
    load = 1'b0; pause = 1'b0; en = 1'b0;

    // Async reset mid-count
    load = 1'b1; lv_a = 8'h12;
    tick(); chk_a("load_pre_rst", 8'h12, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick(); chk_a("count_13", 8'h13, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_a("async_rst", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); chk_a("after_rst", 8'h01, 1'b0, 1'b0);

    // Saturating 3-digit instance, MAX_VAL = 599
    en = 1'b0; load = 1'b1; lv_b = 12'h598;
    tick(); chk_b("b_load_598", 12'h598, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_b($sformatf("b_sat_up_%0d", i), 12'h599, 1'b0, 1'b0);
    end
    en = 1'b0; load = 1'b1; lv_b = 12'h600;
    tick(); chk_b("b_load_600", 12'h599, 1'b0, 1'b1);
    load = 1'b0; clear = 1'b1;
    tick(); chk_b("b_clear", 12'h000, 1'b0, 1'b0);
    clear = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick(); chk_b("b_sat_down_0", 12'h000, 1'b0, 1'b0);
    tick(); chk_b("b_sat_down_1", 12'h000, 1'b0, 1'b0);
    en = 1'b0; load = 1'b1; lv_b = 12'h100;
    tick(); chk_b("b_load_100", 12'h100, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick(); chk_b("b_borrow", 12'h099, 1'b0, 1'b0);
    up_dn = 1'b1;
    tick(); chk_b("b_carry", 12'h100, 1'b0, 1'b0);
    en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
